// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined IEEE-754-style compare / min / max unit.
// Stage 1 classifies both operands; stage 2 forms the result and invalid flag.
module fp_cmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] fp_a,
  input  logic [W-1:0] fp_b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         nv
);

  localparam logic [2:0] OP_LT  = 3'b000;
  localparam logic [2:0] OP_LE  = 3'b001;
  localparam logic [2:0] OP_EQ  = 3'b010;
  localparam logic [2:0] OP_MIN = 3'b011;
  localparam logic [2:0] OP_MAX = 3'b100;

  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand classification (combinational, registered into stage 1)
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_exp_ones, b_exp_ones, a_frac_nz, b_frac_nz;

  assign a_exp      = fp_a[W-2 -: EXP_W];
  assign b_exp      = fp_b[W-2 -: EXP_W];
  assign a_frac     = fp_a[MAN_W-1:0];
  assign b_frac     = fp_b[MAN_W-1:0];
  assign a_exp_ones = &a_exp;
  assign b_exp_ones = &b_exp;
  assign a_frac_nz  = |a_frac;
  assign b_frac_nz  = |b_frac;

  logic         s1_valid, s2_valid;
  logic [2:0]   s1_op;
  logic [W-1:0] s1_a, s1_b;
  logic         s1_sa, s1_sb, s1_za, s1_zb, s1_ia, s1_ib;
  logic         s1_qa, s1_qb, s1_sna, s1_snb;
  logic         s1_mag_lt, s1_mag_eq;

  logic accept, s2_adv, s2_drain;

  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign s2_adv    = s1_valid && (!s2_valid || out_ready);
  assign s2_drain  = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // Stage 2 result logic
  logic a_nan, b_nan, any_nan, any_snan, both_zero;
  logic ord_lt, val_lt, val_eq;
  logic [W-1:0] nxt_result;
  logic         nxt_nv;

  always_comb begin
    a_nan     = s1_qa || s1_sna;
    b_nan     = s1_qb || s1_snb;
    any_nan   = a_nan || b_nan;
    any_snan  = s1_sna || s1_snb;
    both_zero = s1_za && s1_zb;

    // Total order on non-NaN values with -0 < +0; negatives order by reversed magnitude.
    if (s1_sa != s1_sb)
      ord_lt = s1_sa;
    else if (s1_ia || s1_ib)
      ord_lt = s1_sa ? (s1_ia && !s1_ib) : (s1_ib && !s1_ia);
    else
      ord_lt = s1_sa ? (!s1_mag_lt && !s1_mag_eq) : s1_mag_lt;

    val_lt = !both_zero && ord_lt;
    val_eq = both_zero || (s1_mag_eq && (s1_sa == s1_sb));

    nxt_result = '0;
    nxt_nv     = 1'b0;
    case (s1_op)
      OP_LT: begin
        nxt_result[0] = !any_nan && val_lt;
        nxt_nv        = any_nan;
      end
      OP_LE: begin
        nxt_result[0] = !any_nan && (val_lt || val_eq);
        nxt_nv        = any_nan;
      end
      OP_EQ: begin
        nxt_result[0] = !any_nan && val_eq;
        nxt_nv        = any_snan;
      end
      OP_MIN, OP_MAX: begin
        if (a_nan && b_nan)
          nxt_result = CANON_NAN;
        else if (a_nan)
          nxt_result = s1_b;
        else if (b_nan)
          nxt_result = s1_a;
        else if (s1_op == OP_MIN)
          nxt_result = ord_lt ? s1_a : s1_b;
        else
          nxt_result = ord_lt ? s1_b : s1_a;
        nxt_nv = any_snan;
      end
      default: begin
        nxt_result = '0;
        nxt_nv     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sa     <= 1'b0;
      s1_sb     <= 1'b0;
      s1_za     <= 1'b0;
      s1_zb     <= 1'b0;
      s1_ia     <= 1'b0;
      s1_ib     <= 1'b0;
      s1_qa     <= 1'b0;
      s1_qb     <= 1'b0;
      s1_sna    <= 1'b0;
      s1_snb    <= 1'b0;
      s1_mag_lt <= 1'b0;
      s1_mag_eq <= 1'b0;
      result    <= '0;
      nv        <= 1'b0;
    end else begin
      if (accept)
        s1_valid <= 1'b1;
      else if (s2_adv)
        s1_valid <= 1'b0;

      if (s2_adv)
        s2_valid <= 1'b1;
      else if (s2_drain)
        s2_valid <= 1'b0;

      if (accept) begin
        s1_op     <= op;
        s1_a      <= fp_a;
        s1_b      <= fp_b;
        s1_sa     <= fp_a[W-1];
        s1_sb     <= fp_b[W-1];
        s1_za     <= (a_exp == '0) && !a_frac_nz;
        s1_zb     <= (b_exp == '0) && !b_frac_nz;
        s1_ia     <= a_exp_ones && !a_frac_nz;
        s1_ib     <= b_exp_ones && !b_frac_nz;
        s1_qa     <= a_exp_ones && a_frac[MAN_W-1];
        s1_qb     <= b_exp_ones && b_frac[MAN_W-1];
        s1_sna    <= a_exp_ones && a_frac_nz && !a_frac[MAN_W-1];
        s1_snb    <= b_exp_ones && b_frac_nz && !b_frac[MAN_W-1];
        s1_mag_lt <= fp_a[W-2:0] < fp_b[W-2:0];
        s1_mag_eq <= fp_a[W-2:0] == fp_b[W-2:0];
      end

      if (s2_adv) begin
        result <= nxt_result;
        nv     <= nxt_nv;
      end
    end
  end

endmodule

// File: doc/fp_cmp_pipe.md
FP_CMP_PIPE -- requirements
Module: fp_cmp_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width in bits.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width in bits (hidden bit excluded).
REQ-003 SHALL derive local width W = 1+EXP_W+MAN_W, the operand width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand set presented.
REQ-007 SHALL have port in_ready  output  1  block accepts the operand set this cycle.
REQ-008 SHALL have ports fp_a and fp_b  input  W each  IEEE-754-style operands.
REQ-009 SHALL have port op  input  3  operation: 000 LT, 001 LE, 010 EQ, 011 MIN, 100 MAX, others reserved.
REQ-010 SHALL have port out_valid  output  1  result held on outputs.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port result  output  W  MIN/MAX value, or compare bit in bit 0 with upper bits zero.
REQ-013 SHALL have port nv  output  1  invalid-operation flag for the result.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 registers classification (sign, zero, inf, qNaN, sNaN, magnitude-order bits); S2 registers result and nv.
REQ-015 SHALL accept a transfer when in_valid && in_ready; result presented exactly 2 cycles later if never stalled.
REQ-016 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready; no combinational path from in_valid to in_ready.
REQ-017 SHALL advance S1->S2 when s1_valid && (!s2_valid || out_ready); S2 clears when out_valid && out_ready and no new S1 data moves in.
REQ-018 SHALL hold result, nv and out_valid stable while out_valid && !out_ready; no loss or duplication, sustaining 1 result/cycle when out_ready stays high.
REQ-019 SHALL classify: NaN = exp all ones && frac != 0; sNaN = NaN with frac MSB 0; inf = exp all ones && frac == 0; zero = exp 0 && frac 0; subnormals are ordered by raw bits, with no flush.
REQ-020 SHALL order non-NaN values exactly: +0 == -0 for LT/LE/EQ; -inf < finite < +inf; negative magnitudes compare reversed.
REQ-021 LT/LE SHALL return 0 with nv=1 if either operand is any NaN.
REQ-022 EQ SHALL return 0 if either operand is NaN; nv=1 only if either is sNaN.
REQ-023 MIN/MAX SHALL treat -0 < +0; one NaN -> return the other operand; both NaN -> canonical NaN (sign 0, exp all ones, frac MSB 1, rest 0); nv=1 if either is sNaN.
REQ-024 A reserved op SHALL return result 0 with nv=1.
REQ-025 The same arithmetic SHALL hold for any EXP_W>=2, MAN_W>=2, with no hard-coded 8/23 widths.

Reset
REQ-026 While rst is asserted, s1_valid, s2_valid and out_valid SHALL be 0; result and nv SHALL be 0; in_ready SHALL be 1.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations; no result for them appears after rst deasserts.
REQ-028 The first transfer SHALL be accepted in the first clock edge after rst deasserts.

Verification
REQ-029 LT with A=0xBF800000 (-1.0), B=0x3F800000 (+1.0), out_ready=1 -> result=1, nv=0, out_valid 2 cycles after acceptance.
REQ-030 EQ with A=0x80000000, B=0x00000000 -> result=1, nv=0. LE with A=0x7FC00000, B=0x3F800000 -> result=0, nv=1.
REQ-031 MIN with A=0x7F800001 (sNaN), B=0x40000000 -> result=0x40000000, nv=1. MAX with two qNaNs -> 0x7FC00000, nv=0. MIN with A=0x00000000, B=0x80000000 -> 0x80000000.
REQ-032 Back-pressure: issue 4 back-to-back ops, hold out_ready=0 for 5 cycles -> in_ready falls after 2 accepted; outputs stable; releasing out_ready delivers all 4 in order, with none lost.
REQ-033 Reset with 2 ops in flight -> out_valid=0 immediately (asynchronous); no stale result after release.
REQ-034 EXP_W=5, MAN_W=10: LT with A=0x3C00 (1.0), B=0x4000 (2.0) -> result=1; MAX of 0xFC00 (-inf) and 0x0001 -> 0x0001.
